data_mem_ctrl: RTL and testbench

//   Burst load/store sequencer directly upstream of data_mem. Accepts one read or write

---
 rtl/data_mem_ctrl.sv | 108 ++++++++++
 tb/tb_data_mem_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Burst load/store sequencer in front of data_mem: one read or write burst of 1..2^AWIDTH words.
// Optional macro MEM_BOUND_CHECK_EN rejects bursts that would run past the top address.
module data_mem_ctrl #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              OP,
  input  logic [AWIDTH-1:0] BASE,
  input  logic [AWIDTH-1:0] LEN,
  input  logic [DWIDTH-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [DWIDTH-1:0] RDATA,
  output logic              RVALID,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              MEM_EN,
  output logic              MEM_WR,
  output logic              MEM_RD,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [DWIDTH-1:0] MEM_DIN,
  input  logic [DWIDTH-1:0] MEM_DOUT
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_FLUSH, S_DONE} state_t;

  localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

  state_t            state_reg;
  logic [AWIDTH-1:0] ptr_reg;
  logic [AWIDTH-1:0] cnt_reg;
  logic              rvalid_reg;
  logic              err_reg;
  logic              bound_err;

`ifdef MEM_BOUND_CHECK_EN
  // The carry out of BASE+LEN means the last word would lie beyond the top address.
  logic [AWIDTH:0] span;
  assign span      = {1'b0, BASE} + {1'b0, LEN};
  assign bound_err = span[AWIDTH];
`else
  assign bound_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      // Read data from data_mem appears one cycle after the RD strobe.
      rvalid_reg <= (state_reg == S_READ);
      case (state_reg)
        S_IDLE: begin
          err_reg <= 1'b0;
          if (REQ) begin
            ptr_reg <= BASE;
            cnt_reg <= LEN;
            if (bound_err) begin
              err_reg   <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              state_reg <= OP ? S_WRITE : S_READ;
            end
          end
        end
        S_READ: begin
          ptr_reg <= ptr_reg + ONE;
          cnt_reg <= cnt_reg - ONE;
          if (cnt_reg == '0) state_reg <= S_FLUSH;
        end
        S_WRITE: begin
          if (WVALID) begin
            ptr_reg <= ptr_reg + ONE;
            cnt_reg <= cnt_reg - ONE;
            if (cnt_reg == '0) state_reg <= S_DONE;
          end
        end
        S_FLUSH: state_reg <= S_DONE;
        S_DONE: begin
          err_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from the registered state so reset clears them at once.
  assign BUSY     = (state_reg != S_IDLE);
  assign DONE     = (state_reg == S_DONE);
  assign ERR      = err_reg;
  assign WREADY   = (state_reg == S_WRITE);
  assign MEM_RD   = (state_reg == S_READ);
  assign MEM_WR   = WREADY & WVALID;
  assign MEM_EN   = MEM_RD | MEM_WR;
  assign MEM_ADDR = ptr_reg;
  assign MEM_DIN  = MEM_WR ? WDATA : '0;
  assign RVALID   = rvalid_reg;
  assign RDATA    = rvalid_reg ? MEM_DOUT : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl with a data_mem stand-in and a word-level reference memory.
module tb_data_mem_ctrl;

`ifdef MEM_BOUND_CHECK_EN
  localparam bit BOUND_CHK = 1'b1;
`else
  localparam bit BOUND_CHK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ = 1'b0;
  logic       OP = 1'b0;
  logic [3:0] BASE = '0;
  logic [3:0] LEN = '0;
  logic [3:0] WDATA = '0;
  logic       WVALID = 1'b0;
  logic       WREADY, RVALID, BUSY, DONE, ERR, MEM_EN, MEM_WR, MEM_RD;
  logic [3:0] RDATA, MEM_ADDR, MEM_DIN;
  logic [3:0] MEM_DOUT = '0;

  logic [3:0] mem [16];
  logic [3:0] ref_mem [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  data_mem_ctrl #(.AWIDTH(4), .DWIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .BASE(BASE), .LEN(LEN),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .RDATA(RDATA), .RVALID(RVALID),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .MEM_EN(MEM_EN), .MEM_WR(MEM_WR),
    .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  // Stand-in for data_mem: synchronous write, registered read.
  always @(posedge CLK) begin
    if (MEM_EN && MEM_WR) mem[MEM_ADDR] <= MEM_DIN;
    if (MEM_EN && MEM_RD) MEM_DOUT <= mem[MEM_ADDR];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stall: 0 = WVALID always high, 1 = random gaps, 2 = gaps on 2nd and 4th WRITE cycle
  task automatic do_burst(input bit op, input int base, input int len, input bit hold,
                          input int stall, input bit seq);
    int c, k;
    bit wv, exp_err;
    logic [3:0] wd;
    exp_err = BOUND_CHK && (base + len > 15);
    @(negedge CLK);
    REQ = 1'b1; OP = op; BASE = base[3:0]; LEN = len[3:0];
    #1 check("idle_busy", BUSY, 0);
    @(negedge CLK);
    if (hold) begin
      OP = ~op; BASE = 4'($urandom); LEN = 4'($urandom);
    end else begin
      REQ = 1'b0;
    end
    if (exp_err) begin
      #1;
      check("err_done", DONE, 1);
      check("err_flag", ERR, 1);
      check("err_noen", MEM_EN, 0);
    end else if (op) begin
      k = 0; c = 0;
      while (k <= len && c < 200) begin
        wv = (stall == 0) ? 1'b1 : (stall == 1) ? ($urandom_range(0, 3) != 0) : !(c == 1 || c == 3);
        wd = seq ? k[3:0] : 4'($urandom);
        WVALID = wv; WDATA = wd;
        #1;
        check("wready", WREADY, 1);
        check("wr_en", MEM_EN, wv);
        check("wr_wr", MEM_WR, wv);
        check("wr_rd", MEM_RD, 0);
        check("wr_done", DONE, 0);
        if (wv) begin
          check("wr_addr", MEM_ADDR, (base + k) % 16);
          check("wr_din", MEM_DIN, wd);
          ref_mem[(base + k) % 16] = wd;
          k++;
        end
        c++;
        @(negedge CLK);
      end
      WVALID = 1'b0;
      if (c >= 200) check("wr_timeout", 0, 1);
      #1;
      check("wdone_done", DONE, 1);
      check("wdone_busy", BUSY, 1);
      check("wdone_err", ERR, 0);
      check("wdone_en", MEM_EN, 0);
    end else begin
      for (int i = 0; i <= len; i++) begin
        #1;
        check("rd_rd", MEM_RD, 1);
        check("rd_en", MEM_EN, 1);
        check("rd_wr", MEM_WR, 0);
        check("rd_addr", MEM_ADDR, (base + i) % 16);
        check("rd_rvalid", RVALID, i > 0);
        if (i > 0) check("rd_data", RDATA, ref_mem[(base + i - 1) % 16]);
        @(negedge CLK);
      end
      #1;
      check("flush_rvalid", RVALID, 1);
      check("flush_data", RDATA, ref_mem[(base + len) % 16]);
      check("flush_en", MEM_EN, 0);
      check("flush_done", DONE, 0);
      @(negedge CLK);
      #1;
      check("rdone_done", DONE, 1);
      check("rdone_rvalid", RVALID, 0);
      check("rdone_err", ERR, 0);
    end
    @(negedge CLK);
    REQ = 1'b0;
    #1;
    check("after_busy", BUSY, 0);
    check("after_done", DONE, 0);
    check("after_en", MEM_EN, 0);
  endtask

  initial begin
    logic [3:0] wa, wb;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_en", MEM_EN, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_done", DONE, 0);
    check("rst_wready", WREADY, 0);
    check("rst_err", ERR, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    do_burst(1'b1, 0, 15, 1'b0, 0, 1'b1);   // full sweep write 0..15
    do_burst(1'b0, 0, 15, 1'b0, 0, 1'b0);   // full sweep read back
    do_burst(1'b1, 4, 2, 1'b0, 2, 1'b0);    // stalled write
    do_burst(1'b0, 14, 3, 1'b0, 0, 1'b0);   // wrap or bound error

    // Reset in the middle of a write burst, between clock edges.
    wa = 4'($urandom); wb = 4'($urandom);
    @(negedge CLK);
    REQ = 1'b1; OP = 1'b1; BASE = 4'd2; LEN = 4'd5;
    @(negedge CLK);
    REQ = 1'b0; WVALID = 1'b1; WDATA = wa;
    @(negedge CLK);
    WDATA = wb;
    @(negedge CLK);
    WDATA = ~wb;
    ref_mem[2] = wa; ref_mem[3] = wb;
    #1 RST = 1'b1;
    #1;
    check("mid_rst_en", MEM_EN, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_wready", WREADY, 0);
    check("mid_rst_wr", MEM_WR, 0);
    @(negedge CLK);
    RST = 1'b0; WVALID = 1'b0;
    do_burst(1'b0, 3, 0, 1'b0, 0, 1'b0);

    // REQ held through the burst and its DONE cycle.
    do_burst(1'b0, 5, 4, 1'b1, 0, 1'b0);
    do_burst(1'b1, 9, 3, 1'b1, 1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      do_burst(1'($urandom_range(0, 1)), $urandom_range(0, 15),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4),
               $urandom_range(0, 3) == 0, 1, 1'b0);
    end
    do_burst(1'b0, 0, 15, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
